mdu_sched: RTL and testbench
============================

MDU_SCHED -- requirements
Module: mdu_sched

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have the port issue, input, 1 bit: qualifies op for one cycle.
REQ-004 SHALL have the port op, input, 4 bits: 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7-15 are no-op.
REQ-005 SHALL have the port rs_val, input, 32 bits: operand A (dividend / multiplicand / mthi-mtlo source).
REQ-006 SHALL have the port rt_val, input, 32 bits: operand B (divisor / multiplier).
REQ-007 SHALL have the port flush, input, 1 bit: exception or interrupt taken on the issuing instruction; suppresses issue.
REQ-008 SHALL have the port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have the port hi, output, 32 bits: the architectural HI register.
REQ-010 SHALL have the port lo, output, 32 bits: the architectural LO register.

Function
REQ-011 SHALL implement the states IDLE, MULT and DIV, with a 4-bit down-counter cnt.
REQ-012 SHALL accept an issue only in IDLE with issue=1 and flush=0; issue while busy=1 is ignored.
REQ-013 SHALL, on an accepted op 1 or 2, latch rs_val and rt_val, load cnt=5 and enter MULT.
REQ-014 SHALL, on an accepted op 3 or 4, latch rs_val and rt_val, load cnt=10 and enter DIV.
REQ-015 SHALL assert busy whenever the state is not IDLE: exactly 5 cycles for mult, 10 cycles for div, starting the cycle after issue.
REQ-016 SHALL decrement cnt every cycle in MULT and DIV; when cnt=1, SHALL write hi/lo and return to IDLE at that edge.
REQ-017 SHALL make the new hi/lo visible in the first cycle that busy=0, and SHALL allow a new issue in that same cycle.
REQ-018 SHALL compute mult as a 64-bit signed product of the latched operands: hi=[63:32], lo=[31:0].
REQ-019 SHALL compute multu as a 64-bit unsigned product.
REQ-020 SHALL compute div as signed division truncating toward zero: lo=quotient, hi=remainder, with the remainder taking the sign of the dividend.
REQ-021 SHALL compute divu as unsigned division: lo=quotient, hi=remainder.
REQ-022 SHALL, for div or divu with a latched divisor of 0, still run the full 10 busy cycles but leave hi and lo unchanged.
REQ-023 SHALL compute signed div 0x80000000 / 0xFFFFFFFF as lo=0x80000000, hi=0.
REQ-024 SHALL, on an accepted op 5, write hi=rs_val at the next edge; busy stays 0 and lo is unchanged.
REQ-025 SHALL, on an accepted op 6, write lo=rs_val at the next edge; busy stays 0 and hi is unchanged.
REQ-026 SHALL NOT alter hi or lo for no-op codes or suppressed issues.
REQ-027 SHALL change hi and lo only at operation completion or on mthi/mtlo; intermediate values are never visible on the outputs.

Reset
REQ-028 SHALL, when reset=1 at an edge, set state=IDLE, cnt=0, busy=0, hi=0, lo=0.
REQ-029 SHALL give reset priority over issue, flush and completion.
REQ-030 SHALL, when reset hits mid-operation, abort that operation and not write back its result.

Configuration
REQ-031 SHALL use the macro MDU_FLUSH_CANCEL_EN.
REQ-032 SHALL, with MDU_FLUSH_CANCEL_EN defined: flush=1 while busy returns the block to IDLE at the next edge, drops the result and leaves hi/lo unchanged; busy=0 the following cycle.
REQ-033 SHALL, with MDU_FLUSH_CANCEL_EN undefined: ignore flush while busy, so the operation completes normally; flush only suppresses a same-cycle issue.

Verification
REQ-034 SHALL cover: issue mult, rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 SHALL cover: issue multu, rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 SHALL cover: issue div, rs=0xFFFFFFF9 (-7), rt=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 SHALL cover: mthi 0x12345678 then mtlo 0x9ABCDEF0 in back-to-back cycles -> hi and lo updated, busy never asserted; then divu by 0 -> 10 busy cycles, hi/lo unchanged.
REQ-038 SHALL cover: issue=1 with flush=1, op=1 -> no busy, hi/lo unchanged; mult issued, then flush at busy cycle 3 -> with MDU_FLUSH_CANCEL_EN busy drops next cycle and hi/lo are unchanged; without it, the result is written after cycle 5.
REQ-039 SHALL cover: reset asserted at div busy cycle 4 -> next cycle busy=0, hi=0, lo=0; a mult issued in the cycle busy falls is accepted.

Source files
------------

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle multiply/divide scheduler holding the HI/LO registers.
// mult/multu take 5 busy cycles, div/divu take 10; mthi/mtlo write in one cycle.
// Optional build macro MDU_FLUSH_CANCEL_EN: when defined, flush while busy
// cancels the running operation without writing HI/LO.
module mdu_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        accept;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, quot, rem;

  assign accept = (state_q == IDLE) && issue && !flush;

  // Result datapath from latched operands; signed divide works on magnitudes so
  // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    a_ext = sgn_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext = sgn_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod  = a_ext * b_ext;
    a_neg = sgn_q && a_q[31];
    b_neg = sgn_q && b_q[31];
    a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    uq    = '0;
    ur    = '0;
    if (b_mag != '0) begin
      uq = a_mag / b_mag;
      ur = a_mag % b_mag;
    end
    quot  = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem   = a_neg ? (~ur + 32'd1) : ur;
  end

  // Next-state: issue acceptance, countdown, writeback at cnt==1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            4'd1, 4'd2: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sgn_d   = (op == 4'd1);
              cnt_d   = 4'd5;
              state_d = MULT;
            end
            4'd3, 4'd4: begin
              a_d     = rs_val;
              b_d     = rt_val;
              sgn_d   = (op == 4'd3);
              cnt_d   = 4'd10;
              state_d = DIV;
            end
            4'd5:    hi_d = rs_val;
            4'd6:    lo_d = rs_val;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (state_q == MULT) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
`ifdef MDU_FLUSH_CANCEL_EN
        // Cancel wins over completion in the same cycle.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = hi_q;
          lo_d    = lo_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// Directed self-checking bench for mdu_sched (follows MDU_FLUSH_CANCEL_EN if defined).
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset, issue, flush;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  mdu_sched dut (
    .clk(clk), .reset(reset), .issue(issue), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles from the current one until busy falls (bounded).
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic do_issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    issue = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    issue = 1'b0; op = 4'd0;
  endtask

  initial begin
    reset = 1'b1; issue = 1'b0; flush = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    // mult -2 * 3
    do_issue(4'd1, 32'hFFFFFFFE, 32'd3);
    check("mult_busy1", {31'b0, busy}, 32'd1);
    check("mult_mid_hi", hi, 32'h0);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    // multu issued in the first idle cycle
    do_issue(4'd2, 32'hFFFFFFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    // div -7 / 2
    do_issue(4'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    // div 7 / -2: remainder follows dividend sign
    do_issue(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    check("div2_lo", lo, 32'hFFFFFFFD);
    check("div2_hi", hi, 32'h00000001);

    // signed overflow case
    do_issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h0);

    // divu 100 / 7
    do_issue(4'd4, 32'd100, 32'd7);
    wait_idle(n);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // mthi then mtlo back to back
    do_issue(4'd5, 32'h12345678, 32'd0);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_lo", lo, 32'd14);
    do_issue(4'd6, 32'h9ABCDEF0, 32'd0);
    check("mtlo_busy", {31'b0, busy}, 32'd0);
    check("mtlo_hi", hi, 32'h12345678);
    check("mtlo_lo", lo, 32'h9ABCDEF0);

    // divu by zero, with an mthi attempted while busy (ignored)
    do_issue(4'd4, 32'd5, 32'd0);
    do_issue(4'd5, 32'hDEADBEEF, 32'd0);
    wait_idle(n);
    check("divz_cycles", n, 32'd9);
    check("divz_hi", hi, 32'h12345678);
    check("divz_lo", lo, 32'h9ABCDEF0);

    // flush suppresses issue; no-op codes do nothing
    flush = 1'b1;
    do_issue(4'd1, 32'd7, 32'd7);
    flush = 1'b0;
    check("flushiss_busy", {31'b0, busy}, 32'd0);
    do_issue(4'd0, 32'h11111111, 32'd1);
    do_issue(4'd9, 32'h22222222, 32'd1);
    check("noop_busy", {31'b0, busy}, 32'd0);
    check("noop_hi", hi, 32'h12345678);
    check("noop_lo", lo, 32'h9ABCDEF0);

    // mult 3*4 with flush in busy cycle 3
    do_issue(4'd1, 32'd3, 32'd4);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
`ifdef MDU_FLUSH_CANCEL_EN
    check("cancel_busy", {31'b0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h12345678);
    check("cancel_lo", lo, 32'h9ABCDEF0);
`else
    wait_idle(n);
    check("noflush_cycles", n, 32'd2);
    check("noflush_hi", hi, 32'h0);
    check("noflush_lo", lo, 32'd12);
`endif

    // reset in div busy cycle 4, then a mult accepted as busy falls
    do_issue(4'd3, 32'd100, 32'd7);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    do_issue(4'd1, 32'h00010000, 32'h00010000);
    check("postrst_busy", {31'b0, busy}, 32'd1);
    wait_idle(n);
    check("postrst_cycles", n, 32'd5);
    check("postrst_hi", hi, 32'h00000001);
    check("postrst_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
